// File: rtl/score_draw.sv
// Multi-digit BCD score renderer: walks every glyph pixel of every digit, drives the
// external glyph ROM, and re-times coordinates/flags to the ROM latency before plotting.
module score_draw #(
    parameter int          NUM_DIGITS = 4,
    parameter int          GLYPH_W    = 14,
    parameter int          GLYPH_H    = 15,
    parameter int          GAP        = 2,
    parameter int          ADDR_W     = 8,
    parameter int          ROM_LAT    = 1,
    parameter logic [23:0] KEY_COLOUR = 24'h000000,
    parameter logic [23:0] ERR_COLOUR = 24'hFF0000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [7:0]              x,
    input  logic [7:0]              y,
    input  logic                    lz_blank,
    output logic [ADDR_W-1:0]       glyph_addr,
    output logic [3:0]              glyph_sel,
    input  logic [23:0]             glyph_q,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              x_draw,
    output logic [7:0]              y_draw,
    output logic [23:0]             colour,
    output logic                    plot,
    output logic [1:0]              fsm_state
);

    localparam int COL_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FCNT_W = $clog2(ROM_LAT + 1);
    localparam logic [7:0] STEP = 8'(GLYPH_W + GAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic [DIG_W-1:0]        dig;
    logic [FCNT_W-1:0]       fcnt;
    logic [ADDR_W-1:0]       pix;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [7:0]              x_base;
    logic [7:0]              y_r;
    logic                    lz_r;
    logic                    lead_zero;

    logic       last_col, last_row, last_dig, flush_end;
    logic [3:0] code;
    logic [7:0] iss_x, iss_y;
    logic       iss_valid, iss_blank, iss_err;

    logic [ROM_LAT-1:0] p_valid, p_blank, p_err;
    logic [7:0]         p_x [ROM_LAT];
    logic [7:0]         p_y [ROM_LAT];

    assign last_col  = (col == COL_W'(GLYPH_W - 1));
    assign last_row  = (row == ROW_W'(GLYPH_H - 1));
    assign last_dig  = (dig == DIG_W'(NUM_DIGITS - 1));
    assign flush_end = (fcnt == FCNT_W'(ROM_LAT));

    // Current digit is always the top nibble; the register shifts left per digit.
    assign code      = digits_sh[4*NUM_DIGITS-1 -: 4];
    assign iss_x     = x_base + 8'(col);
    assign iss_y     = y_r + 8'(row);
    assign iss_valid = (state == DRAW);
    assign iss_err   = (code > 4'd9);
    assign iss_blank = lz_r && lead_zero && (code == 4'd0) && !last_dig;

    assign glyph_addr = (state == DRAW) ? pix : '0;
    assign glyph_sel  = (state == DRAW) ? code : 4'd0;

    // start is accepted only in IDLE; busy covers the whole draw and falls in the
    // same cycle as the single-cycle done pulse.
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DRAW;
            DRAW:    if (last_col && last_row && last_dig) state_nx = FLUSH;
            FLUSH:   if (flush_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col       <= '0;
            row       <= '0;
            dig       <= '0;
            pix       <= '0;
            digits_sh <= '0;
            x_base    <= '0;
            y_r       <= '0;
            lz_r      <= 1'b0;
            lead_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                col       <= '0;
                row       <= '0;
                dig       <= '0;
                pix       <= '0;
                digits_sh <= digits;
                x_base    <= x;
                y_r       <= y;
                lz_r      <= lz_blank;
                lead_zero <= 1'b1;
            end
        end else if (state == DRAW) begin
            if (!last_col) begin
                col <= col + COL_W'(1);
                pix <= pix + ADDR_W'(1);
            end else if (!last_row) begin
                col <= '0;
                row <= row + ROW_W'(1);
                pix <= pix + ADDR_W'(1);
            end else begin
                col       <= '0;
                row       <= '0;
                pix       <= '0;
                dig       <= dig + DIG_W'(1);
                x_base    <= x_base + STEP;
                digits_sh <= digits_sh << 4;
                lead_zero <= lead_zero && (code == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fcnt <= '0;
            done <= 1'b0;
        end else begin
            fcnt <= (state == FLUSH) ? fcnt + FCNT_W'(1) : '0;
            done <= (state == FLUSH) && flush_end;
        end
    end

    // Delay line: issue-stage metadata lines up with glyph_q after ROM_LAT clocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid <= '0;
            p_blank <= '0;
            p_err   <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                p_x[i] <= '0;
                p_y[i] <= '0;
            end
        end else begin
            p_valid[0] <= iss_valid;
            p_blank[0] <= iss_blank;
            p_err[0]   <= iss_err;
            p_x[0]     <= iss_x;
            p_y[0]     <= iss_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_blank[i] <= p_blank[i-1];
                p_err[i]   <= p_err[i-1];
                p_x[i]     <= p_x[i-1];
                p_y[i]     <= p_y[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x_draw <= '0;
            y_draw <= '0;
            colour <= '0;
        end else begin
            plot   <= p_valid[ROM_LAT-1] && !p_blank[ROM_LAT-1] &&
                      (p_err[ROM_LAT-1] || (glyph_q != KEY_COLOUR));
            x_draw <= p_x[ROM_LAT-1];
            y_draw <= p_y[ROM_LAT-1];
            colour <= p_err[ROM_LAT-1] ? ERR_COLOUR : glyph_q;
        end
    end

endmodule

// File: tb/tb_score_draw.sv
// Bench for score_draw: a default instance and a 6-digit / 3-cycle-ROM instance, checked
// against a pixel-level reference model through per-instance expected queues.
module tb_score_draw;

    localparam int          GW  = 14;
    localparam int          GH  = 15;
    localparam int          GP  = 2;
    localparam logic [23:0] KEY = 24'h000000;
    localparam logic [23:0] ERR = 24'hFF0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, lz_a = 1'b0;
    logic [15:0] digits_a = '0;
    logic [7:0]  x_a = '0, y_a = '0, addr_a, xd_a, yd_a;
    logic [3:0]  sel_a;
    logic [23:0] q_a, col_a;
    logic        busy_a, done_a, plot_a;
    logic [1:0]  st_a;

    logic        start_b = 1'b0, lz_b = 1'b0;
    logic [23:0] digits_b = '0;
    logic [7:0]  x_b = '0, y_b = '0, addr_b, xd_b, yd_b;
    logic [3:0]  sel_b;
    logic [23:0] q_b, col_b;
    logic        busy_b, done_b, plot_b;
    logic [1:0]  st_b;

    score_draw u_dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .digits(digits_a), .x(x_a), .y(y_a),
        .lz_blank(lz_a), .glyph_addr(addr_a), .glyph_sel(sel_a), .glyph_q(q_a),
        .busy(busy_a), .done(done_a), .x_draw(xd_a), .y_draw(yd_a), .colour(col_a),
        .plot(plot_a), .fsm_state(st_a)
    );

    score_draw #(.NUM_DIGITS(6), .ROM_LAT(3)) u_dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .digits(digits_b), .x(x_b), .y(y_b),
        .lz_blank(lz_b), .glyph_addr(addr_b), .glyph_sel(sel_b), .glyph_q(q_b),
        .busy(busy_b), .done(done_b), .x_draw(xd_b), .y_draw(yd_b), .colour(col_b),
        .plot(plot_b), .fsm_state(st_b)
    );

    int checks = 0;
    int fails  = 0;
    int rom_mode = 0;

    logic [39:0] exp_q[$];
    logic [39:0] exp_b_q[$];
    int          plot_cnt [2];
    logic [15:0] first_xy [2];
    logic [15:0] last_xy  [2];
    bit          seen     [2];

    // Glyph ROM content: mode 0 never returns the key colour, mode 1 keys out even addresses.
    function automatic logic [23:0] rom_fn(input logic [3:0] sel, input int addr, input int mode);
        logic [7:0] a8;
        a8 = addr[7:0];
        if (mode == 1 && (addr % 2) == 0) return KEY;
        return {(mode == 1) ? 8'h40 : 8'h80, 4'h0, sel, a8};
    endfunction

    logic [23:0] ra;
    logic [23:0] rb [3];
    always @(posedge clk) begin
        ra    <= rom_fn(sel_a, int'(addr_a), rom_mode);
        rb[0] <= rom_fn(sel_b, int'(addr_b), rom_mode);
        rb[1] <= rb[0];
        rb[2] <= rb[1];
    end
    assign q_a = ra;
    assign q_b = rb[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (plot_a) begin
            plot_cnt[0]++;
            if (!seen[0]) first_xy[0] = {xd_a, yd_a};
            seen[0] = 1'b1;
            last_xy[0] = {xd_a, yd_a};
            if (exp_q.size() == 0) check("plot_a_unexpected", {xd_a, yd_a, col_a}, 64'hFFFF_FFFF_FFFF);
            else check("plot_a", {xd_a, yd_a, col_a}, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (plot_b) begin
            plot_cnt[1]++;
            if (!seen[1]) first_xy[1] = {xd_b, yd_b};
            seen[1] = 1'b1;
            last_xy[1] = {xd_b, yd_b};
            if (exp_b_q.size() == 0) check("plot_b_unexpected", {xd_b, yd_b, col_b}, 64'hFFFF_FFFF_FFFF);
            else check("plot_b", {xd_b, yd_b, col_b}, exp_b_q.pop_front());
        end
    end

    // Reference: every glyph pixel in reading order, leading zeros suppressed except the LS digit.
    task automatic model_draw(input int which, input logic [23:0] dv, input int n,
                              input int x0, input int y0, input bit lz, input int mode);
        bit          lead;
        bit          blank;
        logic [3:0]  code;
        logic [23:0] q;
        logic [7:0]  px, py;
        lead = 1'b1;
        for (int d = 0; d < n; d++) begin
            code  = dv[4*(n-1-d) +: 4];
            lead  = lead && (code == 4'd0);
            blank = lz && lead && (d != n - 1);
            for (int r = 0; r < GH; r++) begin
                for (int c = 0; c < GW; c++) begin
                    px = 8'((x0 + d * (GW + GP) + c) % 256);
                    py = 8'((y0 + r) % 256);
                    q  = rom_fn(code, r * GW + c, mode);
                    if (!blank && (code > 4'd9 || q != KEY)) begin
                        if (which == 0) exp_q.push_back({px, py, (code > 4'd9) ? ERR : q});
                        else            exp_b_q.push_back({px, py, (code > 4'd9) ? ERR : q});
                    end
                end
            end
        end
    endtask

    task automatic run_draw(input int which, input logic [23:0] dv, input logic [7:0] x0,
                            input logic [7:0] y0, input bit lz, input int mode, input int exp_plots,
                            input int exp_first, input int exp_last, input int restart_at,
                            input int abort_at);
        int n, n_dig, exp_cycles, extra;
        n_dig      = (which == 0) ? 4 : 6;
        exp_cycles = n_dig * GW * GH + ((which == 0) ? 1 : 3) + 2;
        rom_mode   = mode;
        @(negedge clk);
        model_draw(which, dv, n_dig, int'(x0), int'(y0), lz, mode);
        plot_cnt[which] = 0;
        seen[which]     = 1'b0;
        if (which == 0) begin
            digits_a = dv[15:0]; x_a = x0; y_a = y0; lz_a = lz; start_a = 1'b1;
        end else begin
            digits_b = dv; x_b = x0; y_b = y0; lz_b = lz; start_b = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        n = 1;
        check("busy_after_start", (which == 0) ? busy_a : busy_b, 1);
        if (which == 0) begin
            check("addr_first", addr_a, 0);
            check("sel_first", sel_a, dv[15:12]);
        end
        while (!((which == 0) ? done_a : done_b) && n < exp_cycles + 20) begin
            if (n == abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_plot", (which == 0) ? plot_a : plot_b, 0);
                check("abort_busy", (which == 0) ? busy_a : busy_b, 0);
                check("abort_done", (which == 0) ? done_a : done_b, 0);
                exp_q.delete();
                exp_b_q.delete();
                repeat (2) @(negedge clk);
                resetn = 1'b1;
                return;
            end
            if (which == 0 && n == 2)   check("addr_second", addr_a, 1);
            if (which == 0 && n == 211) check("sel_digit1", sel_a, dv[11:8]);
            if (n == restart_at) begin
                if (which == 0) start_a = 1'b1;
                else            start_b = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            n++;
        end
        check("done_cycle", n, exp_cycles);
        check("busy_at_done", (which == 0) ? busy_a : busy_b, 0);
        check("queue_drained", (which == 0) ? exp_q.size() : exp_b_q.size(), 0);
        if (exp_plots >= 0) check("plot_count", plot_cnt[which], exp_plots);
        if (exp_first >= 0) check("first_plot_xy", first_xy[which], exp_first);
        if (exp_last >= 0)  check("last_plot_xy", last_xy[which], exp_last);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if ((which == 0) ? (done_a || busy_a) : (done_b || busy_b)) extra++;
        end
        check("single_done_idle", extra, 0);
        check("sel_idle", (which == 0) ? sel_a : sel_b, 0);
    endtask

    initial begin
        logic [23:0] dv;
        repeat (3) @(negedge clk);
        check("rst_plot", plot_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_sel", sel_a, 0);
        check("rst_xy", {xd_a, yd_a}, 0);
        check("rst_colour", col_a, 0);
        check("rst_state", st_a, 0);
        resetn = 1'b1;

        run_draw(0, 24'h0123, 8'd10, 8'd5, 1'b0, 0, 840, 16'h0A05, 16'h4713, -1, -1);
        run_draw(0, 24'h0123, 8'd10, 8'd5, 1'b1, 0, 630, 16'h1A05, 16'h4713, -1, -1);
        run_draw(0, 24'h0000, 8'd10, 8'd5, 1'b1, 0, 210, 16'h3A05, 16'h4713, -1, -1);
        run_draw(0, 24'h00A0, 8'd10, 8'd5, 1'b0, 0, 840, -1, -1, -1, -1);
        run_draw(0, 24'h00A0, 8'd10, 8'd5, 1'b1, 1, 315, -1, -1, -1, -1);
        run_draw(0, 24'h0123, 8'd10, 8'd5, 1'b0, 1, 420, 16'h0B05, 16'h4713, -1, -1);
        run_draw(0, 24'h4567, 8'd10, 8'd5, 1'b0, 0, 840, -1, -1, 100, -1);
        run_draw(0, 24'h0123, 8'd10, 8'd5, 1'b0, 0, -1, -1, -1, -1, 300);
        check("post_abort_state", st_a, 0);
        run_draw(0, 24'h0123, 8'd10, 8'd5, 1'b0, 0, 840, 16'h0A05, 16'h4713, -1, -1);

        for (int i = 0; i < 4; i++) begin
            dv = {8'h00, 16'($urandom)};
            if ($urandom_range(0, 1) == 1) dv[15:8] = 8'h00;
            run_draw(0, dv, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 1), -1, -1, -1, -1, -1);
        end

        run_draw(1, 24'h012345, 8'd10, 8'd5, 1'b0, 0, 1260, 16'h0A05, -1, -1, -1);
        dv = 24'($urandom);
        dv[23:12] = 12'h00C;
        run_draw(1, dv, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1,
                 -1, -1, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
